// File: rtl/fp16_to_int16.sv
// fp16_to_int16: binary16 to signed 16-bit integer with RNE or LFSR-stochastic rounding.
// Ports: clk/rst_n (sync, active-low); in_valid/in_ready/in_data/in_rmode operand side;
// out_valid/out_ready/out_data/out_flags {invalid, overflow, inexact} result side.
module fp16_to_int16 #(
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int          SHIFT_CAP = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  input  logic        in_rmode,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic [2:0]  out_flags
);
  typedef enum logic [1:0] {IDLE, SHIFT, ROUND, OUT} state_t;
  localparam logic [4:0] CAP = 5'(SHIFT_CAP);
  state_t state, next_state;
  logic sign, rmode, special, nan, lshift, sticky;
  logic [16:0] int_q;
  logic [SHIFT_CAP-1:0] rem;
  logic [4:0] cnt;
  logic [15:0] lfsr;
  logic [4:0] exp_in, e_in, k_raw, k_in;
  logic [10:0] m_in;
  logic left_in, accept, up, ovf;
  logic [16:0] mag;
  logic [15:0] res;
  logic [2:0] flg;
  assign exp_in = in_data[14:10];
  assign m_in = {|exp_in, in_data[9:0]};
  assign e_in = (exp_in == 5'd0) ? 5'd1 : exp_in;
  assign k_raw = 5'd25 - e_in;
  assign k_in = (k_raw > CAP) ? CAP : k_raw;
  assign left_in = e_in >= 5'd25;
  assign in_ready = rst_n && state == IDLE;
  assign accept = in_valid && in_ready;
  assign out_valid = state == OUT;
  always_ff @(posedge clk)
    state <= !rst_n ? IDLE : next_state;
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    next_state = accept ? (left_in ? ROUND : SHIFT) : IDLE;
      SHIFT:   next_state = (cnt == 5'd1) ? ROUND : SHIFT;
      ROUND:   next_state = OUT;
      default: next_state = out_ready ? IDLE : OUT;
    endcase
  end
  // Stochastic rounding compares only the retained remainder; sticky is ignored there.
  always_comb begin
    up = rmode ? (lfsr[SHIFT_CAP-1:0] < rem)
               : (rem[SHIFT_CAP-1] & (|rem[SHIFT_CAP-2:0] | sticky | int_q[0]));
    mag = lshift ? int_q : int_q + 17'(up);
    ovf = sign ? (mag > 17'd32768) : (mag > 17'd32767);
    res = sign ? -mag[15:0] : mag[15:0];
    flg = {2'b00, |rem | sticky};
    if (special) begin
      res = (nan | sign) ? 16'h8000 : 16'h7FFF;
      flg = 3'b100;
    end else if (lshift) begin
      res = ovf ? (sign ? 16'h8000 : 16'h7FFF) : res;
      flg = {1'b0, ovf, 1'b0};
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr <= LFSR_SEED;
      out_data <= 16'h0000;
      out_flags <= 3'b000;
      {sign, rmode, special, nan, lshift, sticky} <= '0;
      int_q <= '0;
      rem <= '0;
      cnt <= '0;
    end else if (state == IDLE && accept) begin
      sign <= in_data[15];
      rmode <= in_rmode;
      special <= exp_in == 5'd31;
      nan <= |in_data[9:0];
      lshift <= left_in;
      int_q <= left_in ? 17'(m_in) << (e_in - 5'd25) : 17'(m_in);
      rem <= '0;
      sticky <= 1'b0;
      cnt <= k_in;
    end else if (state == SHIFT) begin
      sticky <= sticky | rem[0];
      rem <= {int_q[0], rem[SHIFT_CAP-1:1]};
      int_q <= int_q >> 1;
      cnt <= cnt - 5'd1;
    end else if (state == ROUND) begin
      out_data <= res;
      out_flags <= flg;
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end
endmodule

// File: tb/tb_fp16_to_int16.sv
// tb_fp16_to_int16: directed and stochastic checks for fp16_to_int16.
module tb_fp16_to_int16;
  logic clk = 0, rst_n = 0, in_valid = 0, in_rmode = 0, out_ready = 1;
  logic in_ready, out_valid;
  logic [15:0] in_data = 0, out_data;
  logic [2:0] out_flags;
  int tests = 0, fails = 0;
  logic [15:0] ml = 16'hACE1;
  fp16_to_int16 dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_rmode(in_rmode), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_flags(out_flags)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step_model();
    ml = {ml[14:0], ml[15] ^ ml[13] ^ ml[12] ^ ml[10]};
  endtask
  // lat counts edges from the accept edge (counted as 1) to the edge after which out_valid is seen.
  task automatic run(input logic [15:0] d, input logic rm, input int bp,
                     output logic [15:0] q, output logic [2:0] f, output int lat);
    int w;
    @(negedge clk);
    in_valid = 1; in_data = d; in_rmode = rm; out_ready = (bp == 0);
    w = 0;
    while (!in_ready && w < 40) begin @(negedge clk); w++; end
    if (w == 40) check("accept_timeout", 1, 0);
    @(posedge clk); #1;
    in_valid = 0; lat = 1;
    while (!out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    q = out_data; f = out_flags;
    step_model();
    for (int i = 0; i < bp; i++) begin
      @(posedge clk); #1;
      check("bp_valid", out_valid, 1);
      check("bp_data", out_data, q);
      check("bp_flags", out_flags, f);
      check("bp_in_ready", in_ready, 0);
    end
    out_ready = 1;
    @(posedge clk); #1;
    check("post_out_valid", out_valid, 0);
    check("post_in_ready", in_ready, 1);
  endtask
  task automatic do_reset();
    @(negedge clk); rst_n = 0;
    @(negedge clk); rst_n = 1;
    ml = 16'hACE1;
  endtask
  logic [15:0] vin [12] = '{16'h3E00, 16'h4100, 16'hC200, 16'h0001, 16'h7800, 16'hF800,
                            16'h7C00, 16'h7E00, 16'hFC00, 16'h3C00, 16'h6400, 16'h3A00};
  logic [15:0] vout[12] = '{16'h0002, 16'h0002, 16'hFFFD, 16'h0000, 16'h7FFF, 16'h8000,
                            16'h7FFF, 16'h8000, 16'h8000, 16'h0001, 16'h0400, 16'h0001};
  logic [2:0]  vflg[12] = '{3'b001, 3'b001, 3'b000, 3'b001, 3'b010, 3'b000,
                            3'b100, 3'b100, 3'b100, 3'b000, 3'b000, 3'b001};
  int          vlat[12] = '{12, 11, 11, 14, 2, 2, 2, 2, 2, 12, 2, 13};
  initial begin
    logic [15:0] q, first;
    logic [2:0] f;
    logic e;
    int lat, ones;
    repeat (3) @(negedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_flags", out_flags, 0);
    rst_n = 1;
    #1 check("release_in_ready", in_ready, 1);
    for (int i = 0; i < 12; i++) begin
      run(vin[i], 0, 0, q, f, lat);
      check($sformatf("data_%h", vin[i]), q, vout[i]);
      check($sformatf("flags_%h", vin[i]), f, vflg[i]);
      check($sformatf("lat_%h", vin[i]), lat, vlat[i]);
    end
    run(16'h4100, 0, 5, q, f, lat);
    check("bp_result", q, 16'h0002);
    check("bp_res_flags", f, 3'b001);
    e = ml[11:0] < 12'd1024;
    run(16'h3400, 1, 0, q, f, lat);
    check("post_bp_stoch", q, {15'd0, e});
    @(negedge clk);
    in_valid = 1; in_data = 16'h3E00; in_rmode = 0; out_ready = 1;
    @(posedge clk); #1 in_valid = 0;
    repeat (4) @(posedge clk);
    @(negedge clk); rst_n = 0;
    @(posedge clk); #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_data", out_data, 0);
    check("midrst_out_flags", out_flags, 0);
    check("midrst_in_ready", in_ready, 0);
    @(negedge clk); rst_n = 1;
    #1 check("midrst_release_ready", in_ready, 1);
    ml = 16'hACE1;
    e = ml[11:0] < 12'd1024;
    run(16'h3400, 1, 0, first, f, lat);
    check("midrst_first", first, {15'd0, e});
    do_reset();
    ones = 0;
    for (int i = 0; i < 4096; i++) begin
      e = ml[11:0] < 12'd1024;
      run(16'h3400, 1, 0, q, f, lat);
      if (i == 0) check("stoch_first_repeat", q, first);
      check("stoch_val", q, {15'd0, e});
      check("stoch_inexact", f, 3'b001);
      ones += int'(q == 16'h0001);
    end
    check("stoch_ones_range", (ones >= 960 && ones <= 1088), 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fp16_to_int16.md
# fp16_to_int16

Converts one IEEE-754 binary16 value into a signed 16-bit integer over a valid/ready handshake. It is the de-normalising counterpart of the FPU's normalise path. It uses an iterative 1-bit-per-cycle right shifter to align the 11-bit significand, then rounds in one of two modes:
- round-to-nearest-even (RNE);
- stochastic, driven by an internal LFSR.

It sits on the FPU result side, feeding integer consumers, and raises invalid, overflow and inexact flags.

## Interface
- `LFSR_SEED`, default `16'hACE1`: LFSR reset value. Must be non-zero.
- `SHIFT_CAP`, default `12`: maximum right-shift iterations. This is also the width of the remainder register.
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `in_valid`  in  1  input word present.
- `in_ready`  out  1  block can accept a word.
- `in_data`  in  16  binary16 operand, laid out as {sign, exp[4:0], frac[9:0]}.
- `in_rmode`  in  1  rounding mode: 0 = RNE, 1 = stochastic. Sampled with `in_data`.
- `out_valid`  out  1  result present.
- `out_ready`  in  1  consumer accepts the result.
- `out_data`  out  16  two's-complement integer result.
- `out_flags`  out  3  {invalid, overflow, inexact}.

## Operation
States: IDLE, SHIFT, ROUND, OUT.

IDLE:
- `in_ready` = 1.
- On `in_valid`, capture the operand and mode, then decode it:
  - m = {exp≠0, frac}
  - e' = (exp==0) ? 1 : exp
- Next state:
  - exp==31: go to ROUND with the special flag set.
  - e' ≥ 25: go to ROUND; left shift by e'−25.
  - otherwise: k = min(25−e', SHIFT_CAP). Go to SHIFT with a counter of k.

SHIFT, once per cycle:
- sticky |= rem[0]
- rem = {int[0], rem[11:1]}
- int >>= 1
- counter −= 1; on reaching 0, go to ROUND.
- For subnormals and e' ≤ 12, k clamps to 12 and int ends at 0. Bits beyond the 12-bit fraction survive only in sticky.

ROUND (1 cycle) computes the result and flags, then goes to OUT:
- NaN (frac≠0): result 16'h8000, invalid = 1.
- ±inf: result 16'h7FFF or 16'h8000, invalid = 1.
- Left-shift case: magnitude = m << (e'−25), up to 5 bits, no rounding.
  - Positive and magnitude > 32767: overflow = 1, saturate to 16'h7FFF.
  - Negative and magnitude > 32768: overflow = 1, saturate to 16'h8000.
  - −32768 exactly (16'hF800) is legal with no flags.
- RNE: up = rem[11] & (|rem[10:0] | sticky | int[0]).
- Stochastic: up = (lfsr[11:0] < rem). Sticky bits do not affect `up`.
- inexact = (rem≠0) | sticky, on the rounding path only.
- Result = sign ? −(int+up) : (int+up). Negative zero yields 16'h0000. The int+up path cannot overflow.
- The LFSR advances exactly once in ROUND, for every transaction regardless of mode.
  - Fibonacci form, taps 16, 14, 13, 11.
  - new bit = l[15]^l[13]^l[12]^l[10]; shifts in at bit 0.

OUT:
- `out_valid` = 1; `out_data` and `out_flags` are held stable.
- On `out_ready`, go to IDLE.

General rules:
- `in_ready` = 0 in SHIFT, ROUND and OUT. There is no overlap between transactions.
- Reset, from any state including mid-SHIFT: state = IDLE and `out_valid` = 0.
  - `out_data` = 16'h0000 and `out_flags` = 3'b000.
  - The LFSR reloads `LFSR_SEED` and the in-flight operand is discarded.
  - `in_ready` = 0 while `rst_n` = 0, and 1 in the first cycle after release.

## Timing
- Accept edge = cycle 0. `out_valid` rises at cycle k+2:
  - k shift cycles, 1 ROUND cycle, then registered into OUT.
  - k = 0 for special values and left-shift cases, giving a latency of 2.
  - Worst-case latency is 14.
- Minimum initiation interval = k+3 cycles, including the OUT handshake cycle and the return to IDLE.
- `out_ready` may be high before `out_valid`. The transfer occurs on the first edge where both are 1.
- `out_data` and `out_flags` change only on entering OUT or on reset.

## Test plan
- 16'h3E00 (1.5), RNE: 16'h0002, flags 3'b001, `out_valid` 12 cycles after accept (k=10). 16'h4100 (2.5), RNE: 16'h0002, flags 3'b001, latency 11.
- 16'hC200 (−3.0): 16'hFFFD, flags 000. 16'h0001 (min subnormal), RNE: 16'h0000, flags 001, latency 14.
- Saturation and special cases, each with latency 2:
  - 16'h7800 → 16'h7FFF, flags 010.
  - 16'hF800 → 16'h8000, flags 000.
  - 16'h7C00 → 16'h7FFF, flags 100.
  - 16'h7E00 → 16'h8000, flags 100.
- Stochastic: 4096 back-to-back 16'h3400 (0.25), rmode = 1.
  - Every result is 0 or 1 and matches a bit-exact LFSR model from `LFSR_SEED`.
  - Count of 1s is within 1024 ± 64.
  - inexact = 1 on all results.
- Backpressure: hold `out_ready` = 0 for 5 cycles after `out_valid`.
  - `out_data`/`out_flags` stay stable, `in_ready` = 0, and the LFSR does not advance.
  - The transfer occurs on the `out_ready` edge; `in_ready` = 1 in the next cycle.
- Reset mid-SHIFT (cycle 4 of k=10):
  - Next cycle: IDLE, `out_valid` = 0, outputs zero.
  - The next 16'h3400 in stochastic mode reproduces the post-reset first-sample value.
